// File: rtl/otp_stream_xor_if.sv
// otp_stream_xor_if: key, data-in and result handshake bundle for the one-time-pad core
interface otp_stream_xor_if #(parameter int W = 8) ();
    logic         key_valid;
    logic         key_ready;
    logic [W-1:0] key_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    modport master (
        output key_valid, key_data, in_valid, in_data, out_ready,
        input  key_ready, in_ready, out_valid, out_data
    );
    modport slave (
        input  key_valid, key_data, in_valid, in_data, out_ready,
        output key_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/otp_stream_xor.sv
// otp_stream_xor: one-time-pad stream cipher, XORs each data word with the oldest unused pad word
module otp_stream_xor #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    otp_stream_xor_if.slave          bus,
    output logic [$clog2(DEPTH):0]   pad_level,
    output logic                     pad_empty,
    output logic                     pad_full,
    output logic                     underrun,
    output logic [CNT_W-1:0]         words_done
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          fire;
    assign pad_empty     = pad_level == '0;
    assign pad_full      = pad_level == (AW+1)'(DEPTH);
    assign bus.key_ready = !pad_full;
    assign bus.in_ready  = !pad_empty && (!bus.out_valid || bus.out_ready);
    assign push          = bus.key_valid && bus.key_ready && !clear;
    assign fire          = bus.in_valid && bus.in_ready && !clear;
    // pad storage: write incoming keys, zeroize each slot as it is consumed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.key_data;
        if (fire) mem[rd_ptr] <= '0;
    end
    // FIFO pointers and exact fill level; full blocks push, empty blocks pop
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pad_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (fire) rd_ptr <= rd_ptr + 1'b1;
            pad_level <= pad_level + (AW+1)'(push) - (AW+1)'(fire);
        end
    end
    // result register: load on fire, drain on out_ready, hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else if (clear) begin
            bus.out_valid <= 1'b0;
        end else if (fire) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data ^ mem[rd_ptr];
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
    // sticky underrun flag and saturating processed-word counter (counter survives clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun   <= 1'b0;
            words_done <= '0;
        end else begin
            underrun <= clear ? 1'b0 : (underrun || (bus.in_valid && pad_empty));
            if (fire && words_done != '1) words_done <= words_done + 1'b1;
        end
    end
endmodule

// File: tb/tb_otp_stream_xor.sv
// tb_otp_stream_xor: vector table plus directed corners plus randomized queue-model scoreboard
module tb_otp_stream_xor;
    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    typedef struct {
        logic [W-1:0] key;
        logic [W-1:0] data;
        logic [W-1:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    logic clear;
    logic [$clog2(DEPTH):0] pad_level;
    logic pad_empty;
    logic pad_full;
    logic underrun;
    logic [CNT_W-1:0] words_done;

    otp_stream_xor_if #(.W(W)) bus ();

    otp_stream_xor #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .bus        (bus),
        .pad_level  (pad_level),
        .pad_empty  (pad_empty),
        .pad_full   (pad_full),
        .underrun   (underrun),
        .words_done (words_done)
    );

    int compared = 0;
    int mismatched = 0;
    int outs = 0;
    logic [W-1:0] kq[$];
    logic [W-1:0] eq[$];
    logic [CNT_W-1:0] wd_m = '0;
    logic und_m = 1'b0;
    logic key_fire = 1'b0;
    logic in_fire = 1'b0;
    vec_t vecs[6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: pad queue and expected-result queue, sampled mid-cycle before each edge
    always @(negedge clk) begin
        logic [W-1:0] k;
        logic [W-1:0] e;
        key_fire = 1'b0;
        in_fire  = 1'b0;
        if (rst) begin
            kq.delete();
            eq.delete();
            wd_m  = '0;
            und_m = 1'b0;
        end else begin
            chk("pad_level", 32'(pad_level), 32'(kq.size()));
            chk("in_ready", 32'(bus.in_ready), 32'(kq.size() != 0 && (!bus.out_valid || bus.out_ready)));
            chk("key_ready", 32'(bus.key_ready), 32'(kq.size() != DEPTH));
            chk("words_done", 32'(words_done), 32'(wd_m));
            chk("underrun", 32'(underrun), 32'(und_m));
            if (clear) begin
                kq.delete();
                eq.delete();
                und_m = 1'b0;
            end else begin
                if (bus.in_valid && kq.size() == 0) und_m = 1'b1;
                if (bus.out_valid && bus.out_ready) begin
                    if (eq.size() == 0) chk("out_extra", 32'd1, 32'd0);
                    else begin
                        e = eq.pop_front();
                        chk("out_data", 32'(bus.out_data), 32'(e));
                        outs++;
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    if (kq.size() == 0) chk("key_underflow", 32'd1, 32'd0);
                    else begin
                        k = kq.pop_front();
                        eq.push_back(bus.in_data ^ k);
                    end
                    if (wd_m != '1) wd_m = wd_m + 1'b1;
                    in_fire = 1'b1;
                end
                if (bus.key_valid && bus.key_ready) begin
                    kq.push_back(bus.key_data);
                    key_fire = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        clear = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_data = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_key(input logic [W-1:0] k);
        logic ok = 1'b0;
        bus.key_valid = 1'b1;
        bus.key_data = k;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.key_ready;
            @(posedge clk);
            #1;
        end
        bus.key_valid = 1'b0;
        if (!ok) chk("key_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_data(input logic [W-1:0] d);
        logic ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("data_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [W-1:0] od;
        vecs[0] = '{8'h3C, 8'h55, 8'h69};
        vecs[1] = '{8'hA5, 8'hFF, 8'h5A};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF};
        vecs[3] = '{8'h00, 8'hAA, 8'hAA};
        vecs[4] = '{8'h0F, 8'hF0, 8'hFF};
        vecs[5] = '{8'h81, 8'h81, 8'h00};

        do_reset();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_pad_level", 32'(pad_level), 32'd0);
        chk("rst_pad_empty", 32'(pad_empty), 32'd1);
        chk("rst_pad_full", 32'(pad_full), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_words_done", 32'(words_done), 32'd0);
        chk("rst_key_ready", 32'(bus.key_ready), 32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_key(vecs[i].key);
        for (int i = 0; i < 6; i++) begin
            send_data(vecs[i].data);
            chk("t1_out_data", 32'(bus.out_data), 32'(vecs[i].exp));
            chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        end
        chk("t1_words_done", 32'(words_done), 32'd6);
        chk("t1_pad_empty", 32'(pad_empty), 32'd1);

        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h11;
        @(negedge clk);
        chk("t2_in_ready_empty", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 chk("t2_underrun_set", 32'(underrun), 32'd1);
        bus.key_valid = 1'b1;
        bus.key_data = 8'h01;
        @(negedge clk);
        chk("t2_in_ready_same_cycle", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 bus.key_valid = 1'b0;
        chk("t2_level_one", 32'(pad_level), 32'd1);
        @(negedge clk);
        chk("t2_in_ready_next", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("t2_out_data", 32'(bus.out_data), 32'h10);
        chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_underrun_sticky", 32'(underrun), 32'd1);

        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_key(8'h10 + 8'(i));
        chk("t3_pad_full", 32'(pad_full), 32'd1);
        chk("t3_key_ready", 32'(bus.key_ready), 32'd0);
        chk("t3_level", 32'(pad_level), 32'(DEPTH));
        bus.key_valid = 1'b1;
        bus.key_data = 8'hEE;
        @(posedge clk);
        #1 bus.key_valid = 1'b0;
        chk("t3_extra_ignored", 32'(pad_level), 32'(DEPTH));
        send_data(8'h00);
        chk("t3_first_key", 32'(bus.out_data), 32'h10);
        chk("t3_key_ready_after_pop", 32'(bus.key_ready), 32'd1);
        chk("t3_level_after_pop", 32'(pad_level), 32'(DEPTH - 1));

        bus.out_ready = 1'b0;
        od = bus.out_data;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h77;
        repeat (3) begin
            @(negedge clk);
            chk("t4_in_ready_stall", 32'(bus.in_ready), 32'd0);
            chk("t4_out_data_hold", 32'(bus.out_data), 32'(od));
            chk("t4_out_valid_hold", 32'(bus.out_valid), 32'd1);
            chk("t4_level_hold", 32'(pad_level), 32'(DEPTH - 1));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send_data(8'h77);
        chk("t4_resume", 32'(bus.out_data), 32'h66);
        send_data(8'h01);
        chk("t4_order", 32'(bus.out_data), 32'h13);

        do_reset();
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("t5_underrun_pre", 32'(underrun), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_key(8'hA0 + 8'(i));
        bus.out_ready = 1'b0;
        send_data(8'h33);
        chk("t5_pending", 32'(bus.out_valid), 32'd1);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        chk("t5_level", 32'(pad_level), 32'd0);
        chk("t5_empty", 32'(pad_empty), 32'd1);
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_underrun", 32'(underrun), 32'd0);
        chk("t5_words_done", 32'(words_done), 32'd1);
        bus.out_ready = 1'b1;

        outs = 0;
        for (int c = 0; c < 10000; c++) begin
            logic was_clear;
            @(posedge clk);
            #1;
            was_clear = clear;
            if (!bus.key_valid || key_fire || was_clear) begin
                bus.key_valid = 1'($urandom_range(0, 1));
                bus.key_data = 8'($urandom);
            end
            if (!bus.in_valid || in_fire || was_clear) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data = 8'($urandom);
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            clear = $urandom_range(0, 499) == 0;
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.key_valid = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_drained", 32'(eq.size()), 32'd0);
        chk("t6_outputs_seen", 32'(outs > 1000), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
